lane_swap_arbiter: RTL and testbench
====================================

# lane_swap_arbiter

Round-robin arbiter that shares one registered lane-swap stage among NREQ requesters. Each requester presents a WIDTH-bit word under valid/ready; the winner's word is optionally pair-swapped (bit 2k with bit 2k+1) according to that requester's configuration bit and captured into a single output register tagged with the winner's index. The block sits between several producers and the single bit-permute pipeline stage, sequencing access to it and applying the per-source swap configuration.

## Interface
- NREQ, 4, number of requesters; 2..16.
- WIDTH, 2, data width in bits; even, ≥2.
- IDW, $clog2(NREQ), width of out_id; derived, not overridden.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  bit i: requester i has a word.
- req_data  input  NREQ*WIDTH  requester i word at [i*WIDTH +: WIDTH].
- req_ready  output  NREQ  bit i: word i accepted this cycle; one-hot or zero.
- cfg_swap  input  NREQ  bit i: apply pair-swap to requester i's words.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  swapped or passed word.
- out_id  output  IDW  index of the requester that supplied out_data.
- out_ready  input  1  consumer takes the word this cycle.

## Operation
- State EMPTY (out_valid=0) / FULL (out_valid=1).
- can_accept = EMPTY | (FULL & out_ready).
- Grant: first i with req_valid[i], searching ptr, ptr+1, …, NREQ-1, 0, …, ptr-1 (mod NREQ); combinational.
- req_ready[g] = can_accept & req_valid[g] for granted g; all other bits 0.
- Accept (any req_ready bit high): out_data ← swap(req_data[g]) if cfg_swap[g], else req_data[g]; out_id ← g; state → FULL; ptr ← (g+1) mod NREQ.
- swap(w): for k in 0..WIDTH/2-1, out[2k]=w[2k+1], out[2k+1]=w[2k].
- FULL & out_ready & no request: state → EMPTY; out_data/out_id hold last value.
- FULL & !out_ready: register held; req_ready=0; ptr unchanged.
- EMPTY & no request: no change.
- cfg_swap is sampled only in the accept cycle. Changing it later does not alter words already captured.
- ptr advances only on accept, never on idle cycles.

## Timing
- Reset values: out_valid=0, out_data=0, out_id=0, ptr=0, state EMPTY. req_ready=0 while rst high.
- Latency: word accepted in cycle N appears with out_valid=1 from cycle N+1.
- Throughput: one word per cycle when out_ready is held high (back-to-back accept while draining).
- req_ready depends combinationally on req_valid, out_ready and state. Registered outputs: out_valid, out_data, out_id.
- Requesters hold req_valid/req_data stable until req_ready. The block does not check this.
- Reset mid-operation: the held word is discarded immediately (asynchronous); no transfer completes in the reset cycle.
- ptr wraps from NREQ-1 to 0.

## Configuration
- LANE_SWAP_ARB_CNT_EN defined:
  - Adds output xfer_cnt (8 bits), which counts accepted words.
  - Saturates at 255; reset to 0.
  - Increments in the same edge as the accept.
- LANE_SWAP_ARB_CNT_EN undefined: port and counter are absent. Other behaviour is identical.

## Test plan
- Reset then idle:
  - Stimulus: rst pulse mid-cycle, then all req_valid=0 for 3 cycles.
  - Required: out_valid=0, out_data=0, out_id=0, req_ready=0 throughout.
- Single swap:
  - Stimulus: req 2, data 2'b01, cfg_swap=4'b0100, out_ready=1.
  - Required: req_ready=4'b0100 in cycle N; out_data=2'b10, out_id=2 in N+1. Repeat with cfg_swap=0 → out_data=2'b01.
- Round-robin fairness:
  - Stimulus: all four req_valid held high, out_ready=1.
  - Required: grant order 0,1,2,3,0,… one per cycle. With only 1 and 3 valid from ptr=2: order 3,1,3,1.
- Backpressure:
  - Stimulus: out_ready=0 after first accept of req 0 (data 2'b10).
  - Required: out_valid stays 1, out_data=2'b10 held, req_ready=0. When out_ready=1, the next requester is accepted that same cycle.
- Reset mid-operation:
  - Stimulus: assert rst while FULL.
  - Required: out_valid=0 immediately; after release, first grant goes to req 0 if valid (ptr=0).
- Counter (macro defined):
  - Stimulus: 260 accepts.
  - Required: xfer_cnt reads 255. Reset → 0.

Source files
------------

// File: rtl/lane_swap_arbiter_if.sv
// Requester/consumer handshake bundle for lane_swap_arbiter.
// The arbiter takes the slave modport; producers and the consumer drive the master side.
interface lane_swap_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 2
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       cfg_swap;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_id;
  logic                  out_ready;

  modport slave (
    input  req_valid, req_data, cfg_swap, out_ready,
    output req_ready, out_valid, out_data, out_id
  );

  modport master (
    output req_valid, req_data, cfg_swap, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/lane_swap_arbiter.sv
// Round-robin arbiter feeding one registered pair-swap stage tagged with the winner index.
// Define LANE_SWAP_ARB_CNT_EN to add the saturating 8-bit accepted-word counter xfer_cnt.
module lane_swap_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  lane_swap_arbiter_if.slave   bus
`ifdef LANE_SWAP_ARB_CNT_EN
  ,
  output logic [7:0]           xfer_cnt
`endif
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   id_q, id_d;

  logic             hi_found, lo_found;
  logic [IDW-1:0]   hi_idx, lo_idx, grant_idx;
  logic             can_accept, accept;
  logic [WIDTH-1:0] word, swapped;

  // Rotating priority split in two passes: lowest valid at or above ptr wins,
  // otherwise wrap around to the lowest valid overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = IDW'(i);
      end
      if (bus.req_valid[i] && !hi_found && (i >= 32'(ptr_q))) begin
        hi_found = 1'b1;
        hi_idx   = IDW'(i);
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    word    = bus.req_data[32'(grant_idx)*WIDTH +: WIDTH];
    swapped = '0;
    for (int unsigned k = 0; k < WIDTH/2; k++) begin
      swapped[2*k]   = word[2*k+1];
      swapped[2*k+1] = word[2*k];
    end
  end

  // rst gates the handshake so nothing can appear accepted while the stage is held in reset.
  assign can_accept = (state_q == EMPTY) || bus.out_ready;
  assign accept     = can_accept && lo_found && !rst;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    data_d        = data_q;
    id_d          = id_q;
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready[grant_idx] = 1'b1;
      state_d = FULL;
      data_d  = bus.cfg_swap[grant_idx] ? swapped : word;
      id_d    = grant_idx;
      ptr_d   = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
    end else if ((state_q == FULL) && bus.out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_id    = id_q;

`ifdef LANE_SWAP_ARB_CNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_lane_swap_arbiter.sv
// Directed bench for lane_swap_arbiter: vector table plus reset/backpressure/counter sequences.
module tb_lane_swap_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  lane_swap_arbiter_if #(.NREQ(4), .WIDTH(2)) bus();

`ifdef LANE_SWAP_ARB_CNT_EN
  logic [7:0] xfer_cnt;
`endif

  lane_swap_arbiter #(.NREQ(4), .WIDTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef LANE_SWAP_ARB_CNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  typedef struct {
    logic [3:0] rv;
    logic [7:0] rd;
    logic [3:0] cfg;
    logic       ordy;
    logic [3:0] e_rdy;
    logic       e_v;
    logic [1:0] e_d;
    logic [1:0] e_id;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] rv, input logic [7:0] rd, input logic [3:0] cfg,
                       input logic ordy);
    bus.req_valid = rv;
    bus.req_data  = rd;
    bus.cfg_swap  = cfg;
    bus.out_ready = ordy;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] d, input logic [1:0] id);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, ".out_data"},  32'(bus.out_data),  32'(d));
    chk({tag, ".out_id"},    32'(bus.out_id),    32'(id));
  endtask

  // Pulse reset off the clock edge and release it on a falling edge.
  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // req_data packing: req i at [2i+1:2i]; 8'hE4 gives req0=00 req1=01 req2=10 req3=11.
    tbl[0]  = '{4'b0100, 8'h10, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'b10, 2'd2};
    tbl[1]  = '{4'b0100, 8'h10, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'b01, 2'd2};
    tbl[2]  = '{4'b1111, 8'hE4, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'b11, 2'd3};
    tbl[3]  = '{4'b1111, 8'hE4, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'b00, 2'd0};
    tbl[4]  = '{4'b1111, 8'hE4, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'b01, 2'd1};
    tbl[5]  = '{4'b1010, 8'hE4, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'b11, 2'd3};
    tbl[6]  = '{4'b1010, 8'hE4, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'b01, 2'd1};
    tbl[7]  = '{4'b1010, 8'hE4, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'b11, 2'd3};
    tbl[8]  = '{4'b1010, 8'hE4, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'b01, 2'd1};
    tbl[9]  = '{4'b0000, 8'hE4, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'b01, 2'd1};
    tbl[10] = '{4'b0000, 8'hE4, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'b01, 2'd1};
    tbl[11] = '{4'b1111, 8'hE4, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'b01, 2'd2};
    tbl[12] = '{4'b1111, 8'hE4, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'b01, 2'd2};
    tbl[13] = '{4'b1111, 8'hE4, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'b11, 2'd3};
    tbl[14] = '{4'b0001, 8'h02, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'b01, 2'd0};

    drive(4'b0000, 8'h00, 4'b0000, 1'b0);

    // Reset pulse mid-cycle; requests held high during reset must not be acknowledged.
    #3 rst = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    chk("rst.req_ready", 32'(bus.req_ready), 32'h0);
    chk_out("rst", 1'b0, 2'b00, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      #1 chk("idle.req_ready", 32'(bus.req_ready), 32'h0);
      @(posedge clk);
      #1 chk_out("idle", 1'b0, 2'b00, 2'd0);
      @(negedge clk);
    end

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rv, tbl[i].rd, tbl[i].cfg, tbl[i].ordy);
      #1 chk($sformatf("vec%0d.req_ready", i), 32'(bus.req_ready), 32'(tbl[i].e_rdy));
      @(posedge clk);
      #1 chk_out($sformatf("vec%0d", i), tbl[i].e_v, tbl[i].e_d, tbl[i].e_id);
      @(negedge clk);
    end

    // Backpressure: hold req 0's word while req 1 waits, then accept req 1 on release.
    drive(4'b0000, 8'h00, 4'b0000, 1'b1);
    pulse_reset();
    drive(4'b0001, 8'h02, 4'b0000, 1'b1);
    #1 chk("bp.first_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1 chk_out("bp.first", 1'b1, 2'b10, 2'd0);
    @(negedge clk);
    drive(4'b0010, 8'h04, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp.hold_ready", 32'(bus.req_ready), 32'h0);
      @(posedge clk);
      #1 chk_out("bp.hold", 1'b1, 2'b10, 2'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp.release_ready", 32'(bus.req_ready), 32'h2);
    @(posedge clk);
    #1 chk_out("bp.release", 1'b1, 2'b01, 2'd1);

    // Reset while FULL: output clears asynchronously, ptr restarts at 0.
    @(negedge clk);
    drive(4'b0000, 8'h00, 4'b0000, 1'b0);
    #2 rst = 1'b1;
    #1 chk_out("midrst", 1'b0, 2'b00, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'b1111, 8'hE4, 4'b0000, 1'b1);
    #1 chk("midrst.grant", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1 chk_out("midrst.after", 1'b1, 2'b00, 2'd0);

`ifdef LANE_SWAP_ARB_CNT_EN
    @(negedge clk);
    drive(4'b0000, 8'h00, 4'b0000, 1'b1);
    pulse_reset();
    #1 chk("cnt.reset", 32'(xfer_cnt), 32'd0);
    drive(4'b0001, 8'h01, 4'b0000, 1'b1);
    for (int i = 0; i < 260; i++) begin
      @(posedge clk);
      #1;
      if (i == 9) chk("cnt.ten", 32'(xfer_cnt), 32'd10);
    end
    chk("cnt.sat", 32'(xfer_cnt), 32'd255);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("cnt.rst_clear", 32'(xfer_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
